// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_pkg
//  Description : Shared constants for the MMIO UART controller: register
//                offsets, load/store control encodings and ERR bit indices.
//  Revision    : 1.0 - initial release
// ============================================================================
package mmio_pkg;

    // Register offsets within the 64-byte MMIO window
    localparam logic [5:0] OFF_STATUS  = 6'h00;
    localparam logic [5:0] OFF_RXVALID = 6'h04;
    localparam logic [5:0] OFF_TXDATA  = 6'h08;
    localparam logic [5:0] OFF_RXDATA  = 6'h0C;
    localparam logic [5:0] OFF_CYCLES  = 6'h10;
    localparam logic [5:0] OFF_INSTRS  = 6'h14;
    localparam logic [5:0] OFF_CNTRST  = 6'h18;
    localparam logic [5:0] OFF_ERR     = 6'h1C;
    localparam logic [5:0] OFF_IRQEN   = 6'h20;

    // ld_st_ctrl encodings driven by the MIPS decoder
    typedef enum logic [2:0] {
        LS_LB  = 3'b000,
        LS_LH  = 3'b001,
        LS_LW  = 3'b010,
        LS_LBU = 3'b011,
        LS_LHU = 3'b100,
        LS_SB  = 3'b101,
        LS_SH  = 3'b110,
        LS_SW  = 3'b111
    } ls_ctrl_e;

    // ERR register bit positions
    localparam int ERR_TX_OVF = 0;
    localparam int ERR_RX_UNF = 1;
    localparam int ERR_W      = 2;

    // Stores are the upper half of the encoding, except LHU which shares bit 2
    function automatic logic is_store(input logic [2:0] ls);
        return ls[2] && (ls != LS_LHU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_uart_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_uart_ctrl_if
//  Description : CPU load/store bus plus UART byte streams seen by the MMIO
//                UART controller. master = CPU/UART side, slave = controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mmio_uart_ctrl_if #(
    parameter int DATA_W = 8
);
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [2:0]        ld_st_ctrl;
    logic              mem_to_reg;
    logic              stall;
    logic              inst_retire;
    logic [31:0]       rdata;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    modport master (
        output addr, wdata, ld_st_ctrl, mem_to_reg, stall, inst_retire,
        output tx_ready, rx_data, rx_valid,
        input  rdata, tx_data, tx_valid, rx_ready
    );

    modport slave (
        input  addr, wdata, ld_st_ctrl, mem_to_reg, stall, inst_retire,
        input  tx_ready, rx_data, rx_valid,
        output rdata, tx_data, tx_valid, rx_ready
    );
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Synchronous first-word-fall-through FIFO with occupancy
//                count. A push while full is accepted only if a pop frees
//                an entry in the same cycle; a pop while empty is ignored.
//                DEPTH must be a power of two so pointers wrap naturally.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic                   push,
    input  wire logic                   pop,
    input  wire logic [WIDTH-1:0]       din,
    output logic      [WIDTH-1:0]       dout,
    output logic                        full,
    output logic                        empty,
    output logic      [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (AW+1)'(DEPTH));
    assign count     = r_count;
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    // Empty FIFO presents zero rather than a stale entry
    assign dout      = empty ? '0 : r_mem[r_rd_ptr];

    // Storage write; contents need no reset because dout is masked when empty
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/mmio_uart_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_uart_ctrl
//  Description : MMIO decoder between the MIPS datapath and the UART core.
//                TX/RX FIFOs, sticky error flags, status with FIFO levels,
//                cycle/instruction counters. Read data is combinational.
//                Optional interrupt output and IRQEN register are built when
//                MMIO_UART_IRQ_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module mmio_uart_ctrl
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          TX_DEPTH  = 8,
    parameter int          RX_DEPTH  = 8,
    parameter int          DATA_W    = 8
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    mmio_uart_ctrl_if.slave bus
`ifdef MMIO_UART_IRQ_EN
    ,
    output logic            irq
`endif
);
    localparam int TX_CW = $clog2(TX_DEPTH) + 1;
    localparam int RX_CW = $clog2(RX_DEPTH) + 1;

    logic              w_hit;
    logic [5:0]        w_off;
    logic              w_st;
    logic              w_ld;
    logic              w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
    logic              w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
    logic [DATA_W-1:0] w_tx_dout, w_rx_dout;
    logic [TX_CW-1:0]  w_tx_count;
    logic [RX_CW-1:0]  w_rx_count;
    logic              w_tx_ovf, w_rx_unf;
    logic              w_cnt_rst, w_err_wr;
    logic [31:0]       w_rdata;
    logic [ERR_W-1:0]  r_err;
    logic [31:0]       r_cycles;
    logic [31:0]       r_instrs;

    // Address decode and access qualification; stall kills every side effect
    assign w_hit     = (bus.addr[31:6] == BASE_ADDR[31:6]);
    assign w_off     = bus.addr[5:0];
    assign w_st      = w_hit & is_store(bus.ld_st_ctrl) & ~bus.stall;
    assign w_ld      = w_hit & bus.mem_to_reg & ~bus.stall;

    assign w_tx_push = w_st & (w_off == OFF_TXDATA);
    assign w_tx_pop  = ~w_tx_empty & bus.tx_ready;
    assign w_rx_push = bus.rx_valid & ~w_rx_full;
    assign w_rx_pop  = w_ld & (w_off == OFF_RXDATA);
    assign w_cnt_rst = w_st & (w_off == OFF_CNTRST);
    assign w_err_wr  = w_st & (w_off == OFF_ERR);

    // Overflow only when the push cannot ride on a same-cycle drain
    assign w_tx_ovf  = w_tx_push & w_tx_full & ~w_tx_pop;
    assign w_rx_unf  = w_rx_pop & w_rx_empty;

    sync_fifo #(.DEPTH(TX_DEPTH), .WIDTH(DATA_W)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_tx_push),
        .pop   (w_tx_pop),
        .din   (bus.wdata[DATA_W-1:0]),
        .dout  (w_tx_dout),
        .full  (w_tx_full),
        .empty (w_tx_empty),
        .count (w_tx_count)
    );

    sync_fifo #(.DEPTH(RX_DEPTH), .WIDTH(DATA_W)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_rx_push),
        .pop   (w_rx_pop),
        .din   (bus.rx_data),
        .dout  (w_rx_dout),
        .full  (w_rx_full),
        .empty (w_rx_empty),
        .count (w_rx_count)
    );

    assign bus.tx_data  = w_tx_dout;
    assign bus.tx_valid = ~w_tx_empty;
    assign bus.rx_ready = ~w_rx_full;
    assign bus.rdata    = w_rdata;

    // Store data above the character width is never consumed
    generate
        if (DATA_W < 32) begin : g_wdata_unused
            logic w_unused_wdata;
            assign w_unused_wdata = ^bus.wdata[31:DATA_W];
        end
    endgenerate

`ifdef MMIO_UART_IRQ_EN
    logic [2:0] r_irqen;
    logic       r_irq;
    logic [2:0] w_irq_cond;

    assign w_irq_cond = {|r_err, w_tx_empty, ~w_rx_empty};
    assign irq        = r_irq;

    // Interrupt enables and registered interrupt request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irqen <= '0;
            r_irq   <= 1'b0;
        end else begin
            if (w_st && (w_off == OFF_IRQEN)) r_irqen <= bus.wdata[2:0];
            r_irq <= |(r_irqen & w_irq_cond);
        end
    end
`endif

    // Sticky error flags: hardware set wins, software clears by writing 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= '0;
        end else begin
            if (w_tx_ovf)                              r_err[ERR_TX_OVF] <= 1'b1;
            else if (w_err_wr && bus.wdata[ERR_TX_OVF]) r_err[ERR_TX_OVF] <= 1'b0;
            if (w_rx_unf)                              r_err[ERR_RX_UNF] <= 1'b1;
            else if (w_err_wr && bus.wdata[ERR_RX_UNF]) r_err[ERR_RX_UNF] <= 1'b0;
        end
    end

    // Free-running counters; a counter-reset store beats the increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycles <= '0;
            r_instrs <= '0;
        end else if (w_cnt_rst) begin
            r_cycles <= '0;
            r_instrs <= '0;
        end else begin
            r_cycles <= r_cycles + 32'd1;
            if (bus.inst_retire && !bus.stall) r_instrs <= r_instrs + 32'd1;
        end
    end

    // Combinational read mux to the writeback stage
    always_comb begin
        w_rdata = '0;
        if (w_hit && !bus.stall) begin
            case (w_off)
                OFF_STATUS:  w_rdata = {8'h00, 8'(w_rx_count), 8'(w_tx_count),
                                        6'h00, ~w_rx_empty, ~w_tx_full};
                OFF_RXVALID: w_rdata = {31'h0, ~w_rx_empty};
                OFF_RXDATA:  w_rdata = 32'(w_rx_dout);
                OFF_CYCLES:  w_rdata = r_cycles;
                OFF_INSTRS:  w_rdata = r_instrs;
                OFF_ERR:     w_rdata = 32'(r_err);
`ifdef MMIO_UART_IRQ_EN
                OFF_IRQEN:   w_rdata = 32'(r_irqen);
`endif
                default:     w_rdata = '0;
            endcase
        end
    end
endmodule
`default_nettype wire
